// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// store geometry and the header word-count decode.
package imem_loader_pkg;

  localparam int IMEM_DEPTH = 64;
  localparam int IMEM_AW    = 6;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } ld_state_e;

  // Header byte 0 means a full image; anything larger than the store saturates.
  function automatic logic [6:0] hdr_count(input logic [7:0] b);
    if (b == 8'd0 || b > 8'(IMEM_DEPTH))
      return 7'(IMEM_DEPTH);
    else
      return b[6:0];
  endfunction

endpackage

// File: rtl/imem_loader_store.sv
// imem_store: DEPTH x 32 instruction array with one synchronous write port and
// one combinational read port for the fetch path. Contents are never reset.
module imem_store
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = IMEM_AW
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader and instruction memory for the MIPS fetch path.
// Define IMEM_LOADER_CHECKSUM_EN to build the trailing XOR checksum check.
//
// state | meaning
// IDLE  | clear counters, move to HDR
// HDR   | accept word-count byte
// DATA  | assemble big-endian words and write them
// CSUM  | compare checksum byte with running XOR
// DONE  | image valid, core runs
// ERR   | checksum mismatch, core held
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  input  logic                     reload,
  input  logic [$clog2(DEPTH)-1:0] A,
  output logic [31:0]              RD,
  output logic                     cpu_run,
  output logic                     load_err,
  output logic [6:0]               words_loaded
);

  localparam int AW = $clog2(DEPTH);

  ld_state_e   state_q, state_d;
  logic [6:0]  n_q, n_d;
  logic [6:0]  words_q, words_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] asm_q, asm_d;
  logic        accept;
  logic        we;
  logic [31:0] wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  xor_q, xor_d;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      words_q <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      words_q <= words_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    words_d    = words_q;
    idx_d      = idx_q;
    asm_d      = asm_q;
    we         = 1'b0;
    wdata      = {asm_q, byte_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    byte_ready = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
    accept     = byte_valid && byte_ready;

    case (state_q)
      S_IDLE: begin
        words_d = '0;
        idx_d   = '0;
        asm_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d   = '0;
`endif
        state_d = S_HDR;
      end
      S_HDR: begin
        if (accept) begin
          n_d     = hdr_count(byte_data);
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d = xor_q ^ byte_data;
`endif
          if (idx_q == 2'd3) begin
            we      = 1'b1;
            words_d = words_q + 7'd1;
            idx_d   = '0;
            if (words_q + 7'd1 == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
`endif
            end
          end else begin
            asm_d = {asm_q[15:0], byte_data};
            idx_d = idx_q + 2'd1;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) state_d = (byte_data == xor_q) ? S_DONE : S_ERR;
      end
      S_ERR: begin
        if (reload) state_d = S_IDLE;
      end
`endif
      S_DONE: begin
        if (reload) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  imem_store #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_store (
    .clk_i  (CLK),
    .we_i   (we),
    .waddr_i(words_q[AW-1:0]),
    .wdata_i(wdata),
    .raddr_i(A),
    .rdata_o(RD)
  );

  assign cpu_run      = (state_q == S_DONE);
  assign words_loaded = words_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign load_err     = (state_q == S_ERR);
`else
  assign load_err     = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; follows IMEM_LOADER_CHECKSUM_EN
// so the same bench covers both builds.
module tb_imem_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        reload = 1'b0;
  logic [5:0]  A = 6'd0;
  logic [31:0] RD;
  logic        cpu_run;
  logic        load_err;
  logic [6:0]  words_loaded;

  int total  = 0;
  int passed = 0;

  imem_loader dut (
    .CLK         (CLK),
    .RST         (RST),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .reload      (reload),
    .A           (A),
    .RD          (RD),
    .cpu_run     (cpu_run),
    .load_err    (load_err),
    .words_loaded(words_loaded)
  );

  always #5 CLK = ~CLK;

  // Offer one byte after 'gap' idle cycles and hold it until the handshake edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(posedge CLK);
    #1;
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (!byte_ready && t < 20) begin
      @(posedge CLK); #1;
      t++;
    end
    if (!byte_ready) begin
      total++;
      $display("FAIL send_byte_timeout: byte_ready stayed 0 for byte %02h", b);
      byte_valid = 1'b0;
    end else begin
      @(posedge CLK); #1;
      byte_valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 0);
  endtask

  task automatic send_csum(input logic [7:0] c);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(c, 0);
`endif
  endtask

  task automatic pulse_reload();
    @(posedge CLK); #1;
    reload = 1'b1;
    @(posedge CLK); #1;
    reload = 1'b0;
  endtask

  task automatic check_rd(input logic [5:0] addr, input logic [31:0] exp, input string nm);
    A = addr;
    #1;
    total++;
    if (RD !== exp) $display("FAIL %s: RD[%0d]=%08h expected %08h", nm, addr, RD, exp);
    else passed++;
  endtask

  task automatic check_bit(input logic got, input logic exp, input string nm);
    total++;
    if (got !== exp) $display("FAIL %s: got %b expected %b", nm, got, exp);
    else passed++;
  endtask

  task automatic check_words(input logic [6:0] exp, input string nm);
    total++;
    if (words_loaded !== exp) $display("FAIL %s: words_loaded=%0d expected %0d", nm, words_loaded, exp);
    else passed++;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    #1;
    check_bit(byte_ready, 1'b0, "reset_byte_ready");
    check_bit(cpu_run, 1'b0, "reset_cpu_run");
    check_bit(load_err, 1'b0, "reset_load_err");
    check_words(7'd0, "reset_words");
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_basic_load();
    send_byte(8'h02, 0);
    send_word(32'h20080005);
    for (int i = 0; i < 3; i++) send_byte(8'h00, 0);
    check_bit(cpu_run, 1'b0, "basic_run_before_last");
    send_byte(8'h00, 0);
    send_csum(8'h2D);
    check_bit(cpu_run, 1'b1, "basic_cpu_run");
    check_bit(byte_ready, 1'b0, "basic_ready_done");
    check_words(7'd2, "basic_words");
    check_rd(6'd0, 32'h20080005, "basic_mem0");
    check_rd(6'd1, 32'h00000000, "basic_mem1");
  endtask

  task automatic test_reload_load();
    pulse_reload();
    check_bit(cpu_run, 1'b0, "reload_run_drop");
    send_byte(8'h01, 0);
    check_bit(cpu_run, 1'b0, "reload_run_low_hdr");
    for (int i = 3; i >= 0; i--) begin
      check_bit(cpu_run, 1'b0, "reload_run_low_data");
      send_byte(8'(32'hAC010004 >> (8 * i)), 0);
    end
    send_csum(8'hA9);
    check_bit(cpu_run, 1'b1, "reload_run_high");
    check_rd(6'd0, 32'hAC010004, "reload_mem0");
    check_rd(6'd1, 32'h00000000, "reload_mem1_kept");
  endtask

  task automatic test_gaps();
    pulse_reload();
    send_byte(8'h01, $urandom_range(0, 3));
    send_byte(8'hDE, $urandom_range(0, 3));
    send_byte(8'hAD, $urandom_range(0, 3));
    check_words(7'd0, "gap_words_mid");
    send_byte(8'hBE, 5);
    send_byte(8'hEF, $urandom_range(0, 3));
    send_csum(8'h22);
    check_bit(cpu_run, 1'b1, "gap_cpu_run");
    check_words(7'd1, "gap_words");
    check_rd(6'd0, 32'hDEADBEEF, "gap_mem0");
  endtask

  task automatic test_full_image();
    pulse_reload();
    send_byte(8'h00, 0);
    for (int i = 0; i < 256; i++) send_byte(8'(i), 0);
    send_csum(8'h00);
    check_words(7'd64, "full_words");
    check_bit(cpu_run, 1'b1, "full_cpu_run");
    check_rd(6'd0, 32'h00010203, "full_mem0");
    check_rd(6'd63, 32'hFCFDFEFF, "full_mem63");
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    repeat (3) begin
      @(posedge CLK); #1;
      check_bit(byte_ready, 1'b0, "full_extra_not_ready");
    end
    byte_valid = 1'b0;
    check_words(7'd64, "full_words_after_extra");
  endtask

  task automatic test_reset_midload();
    pulse_reload();
    send_byte(8'h03, 0);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h11 + i), 0);
    RST = 1'b0;
    #1;
    check_bit(byte_ready, 1'b0, "rst_mid_ready");
    check_bit(cpu_run, 1'b0, "rst_mid_run");
    check_bit(load_err, 1'b0, "rst_mid_err");
    check_words(7'd0, "rst_mid_words");
    @(negedge CLK);
    RST = 1'b1;
    send_byte(8'h01, 0);
    send_word(32'h12345678);
    send_csum(8'h08);
    check_bit(cpu_run, 1'b1, "rst_fresh_run");
    check_words(7'd1, "rst_fresh_words");
    check_rd(6'd0, 32'h12345678, "rst_fresh_mem0");
    check_rd(6'd1, 32'h04050607, "rst_mem1_kept");
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum_err();
    pulse_reload();
    send_byte(8'h02, 0);
    send_word(32'h20080005);
    send_word(32'h00000000);
    send_byte(8'h00, 0);
    check_bit(load_err, 1'b1, "csum_err_flag");
    check_bit(cpu_run, 1'b0, "csum_err_run");
    check_bit(byte_ready, 1'b0, "csum_err_ready");
    pulse_reload();
    check_bit(load_err, 1'b0, "csum_err_cleared");
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_reload_load();
    test_gaps();
    test_full_image();
    test_reset_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum_err();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
